// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences IF/ID/EX/MEM/WB and decodes
// opcode/funct fields into datapath strobes and ALU operations.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal_instr,
    output logic [2:0]  state
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ALU_W   = 4;
    localparam int unsigned OP_W    = 7;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1101;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'b1010;

    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              zero_q;
    logic              illegal_q;

    logic [OP_W-1:0]   opcode;
    logic [2:0]        funct3;
    logic              funct7_b5;
    logic              is_r;
    logic              is_i;
    logic              is_lw;
    logic              is_sw;
    logic              is_beq;
    logic              opcode_ok;
    logic              funct_ok;
    logic              alt;
    logic [ALU_W-1:0]  dec_alu;
    logic              dec_alusrc;
    logic              unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_b5    = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_lw     = (opcode == OP_LW);
    assign is_sw     = (opcode == OP_SW);
    assign is_beq    = (opcode == OP_BEQ);
    assign opcode_ok = is_r | is_i | is_lw | is_sw | is_beq;

    // funct7[5] is meaningful for every R-type op, but for I-type only on shifts-right
    assign alt = funct7_b5 & (is_r | (funct3 == 3'b101));

    // ALU operation decode
    always_comb begin
        dec_alu    = ALU_ADD;
        dec_alusrc = 1'b0;
        funct_ok   = 1'b1;
        if (is_r || is_i) begin
            dec_alusrc = is_i;
            case (funct3)
                3'b000:  dec_alu = alt ? ALU_SUB : ALU_ADD;
                3'b001:  begin dec_alu = ALU_SLL; funct_ok = ~alt; end
                3'b010:  begin dec_alu = ALU_SLT; funct_ok = ~alt; end
                3'b100:  begin dec_alu = ALU_XOR; funct_ok = ~alt; end
                3'b101:  dec_alu = alt ? ALU_SRA : ALU_SRL;
                3'b110:  begin dec_alu = ALU_OR;  funct_ok = ~alt; end
                3'b111:  begin dec_alu = ALU_AND; funct_ok = ~alt; end
                default: funct_ok = 1'b0;
            endcase
            if (!funct_ok) begin
                dec_alu = ALU_ADD;
            end
        end else if (is_lw || is_sw) begin
            dec_alusrc = 1'b1;
        end else if (is_beq) begin
            dec_alu = ALU_SUB;
        end
    end

    // State register, branch-flag capture and sticky illegal flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EX) begin
                zero_q <= Zero;
            end
            if (state_q == S_ID && !(opcode_ok && funct_ok)) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    if (instr_valid) state_d = S_ID;
            S_ID:    state_d = opcode_ok ? S_EX : S_WB;
            S_EX:    state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:   if (mem_ready) state_d = S_WB;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Control outputs, decoded from the current state and the held instruction
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUCtrl  = ALU_ADD;
        loadPC   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        case (state_q)
            S_EX: begin
                ALUCtrl = dec_alu;
                ALUSrc  = dec_alusrc;
            end
            S_MEM: begin
                ALUCtrl  = dec_alu;
                ALUSrc   = dec_alusrc;
                MemRead  = is_lw;
                MemWrite = is_sw;
            end
            S_WB: begin
                ALUCtrl  = dec_alu;
                ALUSrc   = dec_alusrc;
                loadPC   = 1'b1;
                PCSrc    = is_beq & zero_q;
                RegWrite = is_r | is_i | is_lw;
                MemToReg = is_lw;
            end
            default: ;
        endcase
    end

    assign state         = 3'(state_q);
    assign illegal_instr = illegal_q;

endmodule
